// File: rtl/i2c_pkg.sv
// i2c_pkg: shared command/phase types and quarter-period helper for the I2C bit controller
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH_A = 3'd1,
        PH_B = 3'd2,
        PH_C = 3'd3,
        PH_D = 3'd4
    } phase_t;

    function automatic int quarter_count(input int in_hz, input int out_hz);
        return in_hz / (4 * out_hz);
    endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// i2c_quarter_timer: counts one quarter SCL period, pausable, with a terminal-count pulse
module i2c_quarter_timer #(
    parameter int QUARTER = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic hold,
    output logic tc
);

    localparam int CW = (QUARTER > 2) ? $clog2(QUARTER) : 1;

    logic [CW-1:0] count;

    assign tc = !clear && !hold && (count == CW'(QUARTER - 1));

    // counter restarts at every phase boundary and freezes while held
    always_ff @(posedge clk) begin
        if (!rst_n || clear || tc)
            count <= '0;
        else if (!hold)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/i2c_bit_controller.sv
// i2c_bit_controller: per-command four-phase SCL/SDA sequencer (optional I2C_CLOCK_STRETCH_EN)
module i2c_bit_controller
    import i2c_pkg::*;
#(
    parameter int INPUT_CLOCK_SPEED  = 2000000,
    parameter int OUTPUT_CLOCK_SPEED = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  cmd_t cmd,
    input  logic cmd_bit,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_oe,
    output logic sda_oe,
    output logic rsp_valid,
    output logic rsp_bit,
    output logic stretching
);

    localparam int QUARTER = quarter_count(INPUT_CLOCK_SPEED, OUTPUT_CLOCK_SPEED);

    generate
        if (QUARTER < 2) begin : g_bad_quarter
            $error("i2c_bit_controller: QUARTER must be at least 2");
        end
    endgenerate

    phase_t state, state_nxt;
    cmd_t   cmd_q, cmd_eff;
    logic   bit_q, bit_eff;
    logic   accept, tc, hold;
    logic   scl_nxt, sda_nxt;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

`ifdef I2C_CLOCK_STRETCH_EN
    assign hold = (state == PH_B) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold = 1'b0;
`endif

    assign stretching = hold;

    i2c_quarter_timer #(.QUARTER(QUARTER)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .hold  (hold),
        .tc    (tc)
    );

    // state, latched command and registered line/response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_q     <= CMD_START;
            bit_q     <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_bit   <= 1'b0;
        end else begin
            state     <= state_nxt;
            scl_oe    <= scl_nxt;
            sda_oe    <= sda_nxt;
            rsp_valid <= (state == PH_D) && tc;
            if (accept) begin
                cmd_q <= cmd;
                bit_q <= cmd_bit;
            end
            if ((state == PH_C) && tc && (cmd_q == CMD_WRITE || cmd_q == CMD_READ))
                rsp_bit <= sda_in;
        end
    end

    // phase sequencing: each phase ends on the timer's terminal count
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? PH_A : IDLE;
            PH_A:    state_nxt = tc ? PH_B : PH_A;
            PH_B:    state_nxt = tc ? PH_C : PH_B;
            PH_C:    state_nxt = tc ? PH_D : PH_C;
            PH_D:    state_nxt = tc ? IDLE : PH_D;
            default: state_nxt = IDLE;
        endcase
    end

    // line levels for the phase being entered; lines hold within a phase and in IDLE
    always_comb begin
        cmd_eff = accept ? cmd : cmd_q;
        bit_eff = accept ? cmd_bit : bit_q;
        scl_nxt = scl_oe;
        sda_nxt = sda_oe;
        if (state_nxt != state && state_nxt != IDLE) begin
            case (cmd_eff)
                CMD_START: begin
                    scl_nxt = (state_nxt == PH_A) ? scl_oe : (state_nxt == PH_D);
                    sda_nxt = (state_nxt == PH_C) || (state_nxt == PH_D);
                end
                CMD_STOP: begin
                    scl_nxt = (state_nxt == PH_A);
                    sda_nxt = (state_nxt != PH_D);
                end
                CMD_WRITE: begin
                    scl_nxt = (state_nxt == PH_A) || (state_nxt == PH_D);
                    sda_nxt = ~bit_eff;
                end
                default: begin
                    scl_nxt = (state_nxt == PH_A) || (state_nxt == PH_D);
                    sda_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_controller.sv
// tb_i2c_bit_controller: directed bench for i2c_bit_controller (honours I2C_CLOCK_STRETCH_EN)
module tb_i2c_bit_controller;
    import i2c_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    cmd_t cmd = CMD_START;
    logic cmd_bit = 1'b0;
    logic scl_in = 1'b1;
    logic sda_in = 1'b1;
    logic scl_oe, sda_oe, rsp_valid, rsp_bit, stretching;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_again_at = 0;
    int stretch_len = 0;

    logic r_scl [0:40];
    logic r_sda [0:40];
    logic r_rv  [0:40];
    logic r_rdy [0:40];
    logic r_rb  [0:40];
    logic r_st  [0:40];

    i2c_bit_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .cmd_bit    (cmd_bit),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .rsp_valid  (rsp_valid),
        .rsp_bit    (rsp_bit),
        .stretching (stretching)
    );

    always #5 clk = ~clk;

    // cycle 0 presents the command; cycle i is the period after the i-th edge
    task automatic issue(input cmd_t c, input logic b, input int n);
        cmd = c;
        cmd_bit = b;
        cmd_valid = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            cmd_valid = (i == valid_again_at);
            scl_in = !(i >= 6 && i < 6 + stretch_len);
            #1;
            r_scl[i] = scl_oe;
            r_sda[i] = sda_oe;
            r_rv[i]  = rsp_valid;
            r_rdy[i] = cmd_ready;
            r_rb[i]  = rsp_bit;
            r_st[i]  = stretching;
        end
        cmd_valid = 1'b0;
        scl_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({scl_oe, sda_oe, rsp_valid, rsp_bit, stretching} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=00000", i, {scl_oe, sda_oe, rsp_valid, rsp_bit, stretching});
            end
        end
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got=%b want=1", cmd_ready);
        end
        n_cmp++;
        if ({scl_oe, sda_oe, rsp_valid} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset_release_lines got=%b want=000", {scl_oe, sda_oe, rsp_valid});
        end
        #1;
    endtask

    task automatic test_start();
        valid_again_at = 8;
        issue(CMD_START, 1'b0, 23);
        valid_again_at = 0;
        for (int i = 1; i <= 23; i++) begin
            n_cmp++;
            if ({r_scl[i], r_sda[i], r_rv[i], r_rdy[i]} !== {i >= 16, i >= 11, i == 21, i >= 21}) begin
                n_bad++;
                $display("FAIL start cyc=%0d scl/sda/rv/rdy got=%b%b%b%b want=%b%b%b%b", i,
                         r_scl[i], r_sda[i], r_rv[i], r_rdy[i], i >= 16, i >= 11, i == 21, i >= 21);
            end
        end
    endtask

    task automatic test_write(input logic b, input logic sdi);
        sda_in = sdi;
        issue(CMD_WRITE, b, 21);
        for (int i = 1; i <= 21; i++) begin
            n_cmp++;
            if ({r_scl[i], r_sda[i], r_rv[i]} !== {!(i >= 6 && i <= 15), ~b, i == 21}) begin
                n_bad++;
                $display("FAIL write%b cyc=%0d scl/sda/rv got=%b%b%b want=%b%b%b", b, i,
                         r_scl[i], r_sda[i], r_rv[i], !(i >= 6 && i <= 15), ~b, i == 21);
            end
        end
        n_cmp++;
        if (r_rb[21] !== sdi) begin
            n_bad++;
            $display("FAIL write%b_rsp_bit got=%b want=%b", b, r_rb[21], sdi);
        end
    endtask

    task automatic test_read_stop();
        for (int k = 0; k < 2; k++) begin
            sda_in = (k == 1);
            issue(CMD_READ, 1'b0, 21);
            n_cmp++;
            if ({r_rb[21], r_rv[21], r_sda[12], r_scl[3], r_scl[8]} !== {k == 1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL read%0d rb/rv/sda/sclA/sclB got=%b%b%b%b%b want=%b1010", k,
                         r_rb[21], r_rv[21], r_sda[12], r_scl[3], r_scl[8], k == 1);
            end
        end
        sda_in = 1'b0;
        issue(CMD_STOP, 1'b0, 22);
        for (int i = 1; i <= 22; i++) begin
            n_cmp++;
            if ({r_scl[i], r_sda[i], r_rv[i]} !== {i <= 5, i <= 15, i == 21}) begin
                n_bad++;
                $display("FAIL stop cyc=%0d scl/sda/rv got=%b%b%b want=%b%b%b", i,
                         r_scl[i], r_sda[i], r_rv[i], i <= 5, i <= 15, i == 21);
            end
        end
        n_cmp++;
        if (r_rb[22] !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_keeps_rsp_bit got=%b want=1", r_rb[22]);
        end
        sda_in = 1'b1;
    endtask

    task automatic test_stretch();
        int done_at;
        int st_cnt;
        done_at = 0;
        st_cnt = 0;
        stretch_len = 7;
        issue(CMD_WRITE, 1'b0, 30);
        stretch_len = 0;
        for (int i = 1; i <= 30; i++) begin
            if (r_rv[i] === 1'b1 && done_at == 0) done_at = i;
            if (r_st[i] === 1'b1) st_cnt++;
        end
`ifdef I2C_CLOCK_STRETCH_EN
        n_cmp++;
        if (done_at != 28) begin
            n_bad++;
            $display("FAIL stretch_rsp_cycle got=%0d want=28", done_at);
        end
        n_cmp++;
        if (st_cnt != 7 || r_st[6] !== 1'b1 || r_st[12] !== 1'b1 || r_st[13] !== 1'b0) begin
            n_bad++;
            $display("FAIL stretch_flag count got=%0d want=7 (c6=%b c12=%b c13=%b)", st_cnt, r_st[6], r_st[12], r_st[13]);
        end
        n_cmp++;
        if (r_scl[17] !== 1'b0 || r_scl[23] !== 1'b1) begin
            n_bad++;
            $display("FAIL stretch_scl c17=%b c23=%b want 0 1", r_scl[17], r_scl[23]);
        end
`else
        n_cmp++;
        if (done_at != 21) begin
            n_bad++;
            $display("FAIL nostretch_rsp_cycle got=%0d want=21", done_at);
        end
        n_cmp++;
        if (st_cnt != 0) begin
            n_bad++;
            $display("FAIL nostretch_flag count got=%0d want=0", st_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int rv_cnt;
        rv_cnt = 0;
        issue(CMD_WRITE, 1'b0, 12);
        n_cmp++;
        if ({r_scl[12], r_sda[12], r_rdy[12]} !== 3'b010) begin
            n_bad++;
            $display("FAIL midreset_pre scl/sda/rdy got=%b%b%b want=010", r_scl[12], r_sda[12], r_rdy[12]);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({scl_oe, sda_oe, cmd_ready, rsp_valid} !== 4'b0010) begin
            n_bad++;
            $display("FAIL midreset scl/sda/rdy/rv got=%b%b%b%b want=0010", scl_oe, sda_oe, cmd_ready, rsp_valid);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) rv_cnt++;
        end
        n_cmp++;
        if (rv_cnt != 0) begin
            n_bad++;
            $display("FAIL midreset_no_rsp got=%0d pulses want=0", rv_cnt);
        end
        issue(CMD_START, 1'b0, 21);
        n_cmp++;
        if ({r_scl[15], r_scl[16], r_sda[10], r_sda[11], r_rv[20], r_rv[21]} !== 6'b010101) begin
            n_bad++;
            $display("FAIL midreset_start got=%b want=010101",
                     {r_scl[15], r_scl[16], r_sda[10], r_sda[11], r_rv[20], r_rv[21]});
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_write(1'b0, 1'b0);
        test_write(1'b1, 1'b1);
        test_read_stop();
        test_stretch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
